// File: rtl/palette_fade_decoder_pkg.sv
// palette_fade_decoder shared package: default palette, fade states,
// brightness limits. Default palette is stored as 12-bit (4-bit nibbles).
package palette_pkg;

  localparam int LVL_W = 5;
  localparam logic [LVL_W-1:0] LEVEL_MAX = 5'd16;

  localparam logic [11:0] ERR_COLOR = 12'hF0F;

  localparam logic [11:0] DEF_PAL [0:7] = '{
    12'hBEB, 12'hDD0, 12'hFFF, 12'hC54,
    12'h7BA, 12'h6CB, 12'h435, 12'hAC5
  };

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RAMP,
    FS_DONE
  } fade_state_t;

endpackage

// File: rtl/palette_fade_decoder_channel_scaler.sv
// channel_scaler: one color channel multiplied by a 0..16 level,
// then shifted right by 4 (level 16 is unity gain).
module channel_scaler
  import palette_pkg::*;
#(
  parameter int CH_W = 4
) (
  input  logic [CH_W-1:0]  i_c,
  input  logic [LVL_W-1:0] i_level,
  output logic [CH_W-1:0]  o_c
);

  logic [CH_W+4:0] w_prod;

  // product width CH_W+5 holds c*16 without overflow
  always_comb begin
    w_prod = (CH_W+5)'(i_c) * (CH_W+5)'(i_level);
    o_c    = w_prod[CH_W+3:4];
  end

endmodule

// File: rtl/palette_fade_decoder.sv
// palette_fade_decoder: palette RAM lookup + global fade, 2-cycle latency.
// Optional fade FSM/scaler enabled by defining PALETTE_FADE_EN.
module palette_fade_decoder
  import palette_pkg::*;
#(
  parameter int IDX_W       = 4,
  parameter int CH_W        = 4,
  parameter int STEP_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid_i,
  input  logic [IDX_W-1:0]  pix_idx_i,
  output logic [3*CH_W-1:0] rgb_o,
  output logic              rgb_valid_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_addr_i,
  input  logic [3*CH_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              frame_tick_i,
  input  logic              fade_start_i,
  input  logic              fade_dir_i,
  output logic              fade_busy_o,
  output logic              fade_done_o
);

  localparam int DEPTH = 2**IDX_W;
  localparam int RGB_W = 3*CH_W;

  // nibble -> CH_W bits, replicated or truncated MSB-first
  function automatic logic [CH_W-1:0] f_nib(input logic [3:0] n);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = 0; i < CH_W; i++)
      r[CH_W-1-i] = n[3-(i%4)];
    return r;
  endfunction

  function automatic logic [RGB_W-1:0] f_def(input int i);
    logic [11:0] c;
    c = (i < 8) ? DEF_PAL[i%8] : ERR_COLOR;
    return {f_nib(c[11:8]), f_nib(c[7:4]), f_nib(c[3:0])};
  endfunction

  logic [RGB_W-1:0] r_pal [DEPTH];
  logic [RGB_W-1:0] r_s1_rgb;
  logic             r_s1_vld;
  logic [RGB_W-1:0] r_rgb;
  logic             r_vld;
  logic [RGB_W-1:0] w_scaled;
  logic             w_wr_ready;

  // same-entry write during a live read is held off one cycle
  assign w_wr_ready = !(pix_valid_i && (wr_addr_i == pix_idx_i));
  assign wr_ready_o = w_wr_ready;

  // palette RAM with per-entry default restore
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_pal[i] <= f_def(i);
    end else if (wr_en_i && w_wr_ready) begin
      r_pal[wr_addr_i] <= wr_data_i;
    end
  end

  // stage 1: palette read and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_rgb <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_rgb <= r_pal[pix_idx_i];
      r_s1_vld <= pix_valid_i;
    end
  end

  // stage 2: scaled output, blanked when not valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
      r_vld <= 1'b0;
    end else begin
      r_rgb <= r_s1_vld ? w_scaled : '0;
      r_vld <= r_s1_vld;
    end
  end

  assign rgb_o       = r_rgb;
  assign rgb_valid_o = r_vld;

`ifdef PALETTE_FADE_EN
  localparam int CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_FRAMES - 1);

  fade_state_t      r_state;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic [LVL_W-1:0] r_level;
  logic             r_busy;
  logic             r_done;
  logic [LVL_W-1:0] w_target;

  assign w_target = r_dir ? LEVEL_MAX : '0;

  // fade FSM: level only moves on frame ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FS_IDLE;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_level <= LEVEL_MAX;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        FS_IDLE: begin
          r_done <= 1'b0;
          if (fade_start_i) begin
            r_dir   <= fade_dir_i;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= FS_RAMP;
          end
        end
        FS_RAMP: begin
          if (r_level == w_target) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FS_DONE;
          end else if (frame_tick_i) begin
            if (r_cnt == CNT_MAX) begin
              r_cnt   <= '0;
              r_level <= r_dir ? r_level + 5'd1
                               : r_level - 5'd1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        FS_DONE: begin
          r_done  <= 1'b0;
          r_state <= FS_IDLE;
        end
        default: begin
          r_state <= FS_IDLE;
        end
      endcase
    end
  end

  assign fade_busy_o = r_busy;
  assign fade_done_o = r_done;

  channel_scaler #(.CH_W(CH_W)) u_scale_r (
    .i_c     (r_s1_rgb[3*CH_W-1 -: CH_W]),
    .i_level (r_level),
    .o_c     (w_scaled[3*CH_W-1 -: CH_W])
  );

  channel_scaler #(.CH_W(CH_W)) u_scale_g (
    .i_c     (r_s1_rgb[2*CH_W-1 -: CH_W]),
    .i_level (r_level),
    .o_c     (w_scaled[2*CH_W-1 -: CH_W])
  );

  channel_scaler #(.CH_W(CH_W)) u_scale_b (
    .i_c     (r_s1_rgb[CH_W-1 -: CH_W]),
    .i_level (r_level),
    .o_c     (w_scaled[CH_W-1 -: CH_W])
  );
`else
  logic w_unused_fade;

  // full brightness always; stage 2 is a plain register
  assign w_scaled      = r_s1_rgb;
  assign fade_busy_o   = 1'b0;
  assign fade_done_o   = 1'b0;
  assign w_unused_fade = ^{frame_tick_i, fade_start_i, fade_dir_i};
`endif

endmodule

// File: doc/palette_fade_decoder.md
# palette_fade_decoder

Parametrised successor to the fixed start-screen color decoder. Translates a palette index into RGB through a run-time writable palette RAM, then applies a global brightness level driven by a frame-synchronous fade state machine. Sits between the screen renderers (start, game, end) and the VGA output register. Delivers pipelined pixel data with a valid flag aligned to the input valid.

## Interface
Parameters:
- IDX_W, 4: palette index width; the palette holds 2**IDX_W entries.
- CH_W, 4: bits per color channel; RGB word is 3*CH_W (R in MSBs).
- STEP_FRAMES, 2: number of frame_tick pulses per fade level step, ≥1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid_i  in  1  input index valid (active video).
- pix_idx_i  in  IDX_W  palette index.
- rgb_o  out  3*CH_W  scaled RGB; zero when rgb_valid_o low.
- rgb_valid_o  out  1  pix_valid_i delayed 2 cycles.
- wr_en_i  in  1  palette write request.
- wr_addr_i  in  IDX_W  entry to write.
- wr_data_i  in  3*CH_W  new RGB value.
- wr_ready_o  out  1  high when a write is accepted this cycle.
- frame_tick_i  in  1  one-cycle pulse per VGA frame.
- fade_start_i  in  1  start a fade (pulse).
- fade_dir_i  in  1  1 = fade in (to full), 0 = fade out (to black); sampled with fade_start_i.
- fade_busy_o  out  1  fade in progress.
- fade_done_o  out  1  one-cycle pulse when a fade reaches its end level.

## Operation
- Palette reset contents: entries 0–7 = BEB, DD0, FFF, C54, 7BA, 6CB, 435, AC5 (12-bit, CH_W=4); entries 8 and up = F0F (magenta, error marker). For other CH_W, each 4-bit nibble is replicated or truncated MSB-first to CH_W.
- Write: accepted when wr_en_i && wr_ready_o. wr_ready_o is high except during a pixel-cycle where pix_valid_i is high and wr_addr_i == pix_idx_i; that collision stalls the write by one cycle (requester holds request). Writes outside active video are always accepted.
- Brightness level L: 0..16. Channel out = (c * L) >> 4, computed in CH_W+5 bits, result truncated to CH_W. L=16 passes channel unchanged; L=0 gives black.
- Fade FSM states: IDLE, RAMP, DONE.
  - IDLE: on fade_start_i latch direction → RAMP, fade_busy_o=1.
  - RAMP: frame counter counts frame_tick_i; every STEP_FRAMES ticks L moves 1 toward target (16 or 0). When L equals target → DONE. fade_start_i ignored in RAMP.
  - DONE: fade_done_o=1 for one cycle → IDLE.
  - Starting a fade whose target equals current L: pass through RAMP, DONE on the next cycle, with no tick required.
- L changes only on frame_tick_i cycles, so no frame carries mixed brightness.

## Timing
- Latency: 2 cycles, index→rgb_o. Stage 1: registered palette read and valid. Stage 2: scaling and output register.
- Reset values: rgb_o=0, rgb_valid_o=0, wr_ready_o=1, fade_busy_o=0, fade_done_o=0, L=16, FSM=IDLE, frame counter=0, palette restored to defaults.
- Reset asserted mid-fade or mid-write: all state returns to reset values immediately. The partial write is discarded.
- A write accepted in cycle N is visible to reads that issue in cycle N+1.
- frame_tick_i together with fade_start_i in IDLE: the fade starts, and the tick is not counted.

## Configuration
- PALETTE_FADE_EN defined: fade FSM and scaler are present as described.
- PALETTE_FADE_EN undefined: L is fixed at 16, fade_busy_o and fade_done_o are tied to 0, and fade inputs are ignored. Stage 2 remains a plain register, so latency stays 2 cycles.

## Structure
- Package palette_pkg: default palette constant array, fade state enum, LEVEL_MAX=16, ERR_COLOR.
- Sub-module channel_scaler: one channel multiply-shift. Instantiate 3×.

## Test plan
- Reset, stream indices 0..15 with valid high → 2 cycles later rgb_o = BEB, DD0, FFF, C54, 7BA, 6CB, 435, AC5, then F0F ×8; rgb_valid_o follows valid with 2-cycle delay.
- Write addr 3 = 0F0 during blanking, then read idx 3 → 0F0. Collision: write addr 5 while pix_idx_i=5 valid → wr_ready_o=0 that cycle, old 6CB output, write lands next cycle.
- Fade out with STEP_FRAMES=2 → L drops 1 per 2 ticks; idx 2 reads 777 at L=8 and 000 at L=0; fade_done_o pulses once after 32 ticks.
- Fade in from L=0 → FFF after 32 ticks. A second fade_start_i mid-ramp is ignored, and fade_busy_o stays high.
- Assert rst_n low mid-fade at L=5 → L=16, IDLE, palette defaults, rgb_o=0 while reset is held.
- With PALETTE_FADE_EN undefined: fade_start_i has no effect, idx 0 → BEB, and fade_done_o never asserts.
